// File: rtl/ps2_kb_ctrl_if.sv
// Keyboard-info write port between the PS/2 keyboard controller and the
// memory-mapped KB info register.
//   kb_wraddr : write address (constant KB info region address)
//   kb_wrdata : 32-bit event word
//   kb_we     : single-cycle write strobe
//   frame_err : single-cycle pulse when a received PS/2 frame is discarded
interface ps2_kb_ctrl_if;
    logic [31:0] kb_wraddr;
    logic [31:0] kb_wrdata;
    logic        kb_we;
    logic        frame_err;

    modport master (
        output kb_wraddr,
        output kb_wrdata,
        output kb_we,
        output frame_err
    );

    modport slave (
        input kb_wraddr,
        input kb_wrdata,
        input kb_we,
        input frame_err
    );
endinterface

// File: rtl/ps2_kb_ctrl.sv
// PS/2 keyboard controller: receives PS/2 frames, decodes scan code set 2
// (E0/F0 prefixes, shift and caps-lock state), translates to ASCII and
// writes one event word per key event into the KB info register.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   ps2_clk   : raw PS/2 clock pin (asynchronous)
//   ps2_data  : raw PS/2 data pin (asynchronous)
//   kb        : write port (kb_wraddr, kb_wrdata, kb_we, frame_err)
// Event word: {seq, 4'b0, ext, brk, caps, shift, scan, ascii}
//
// Decoder states:
//   state     | meaning
//   S_IDLE    | waiting for first byte of a key event
//   S_EXT     | E0 seen, extended key pending
//   S_BRK     | F0 seen, break of a normal key pending
//   S_EXT_BRK | E0 F0 seen, break of an extended key pending
module ps2_kb_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [31:0] KB_INFO_ADDR   = 32'h0050_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_kb_ctrl_if.master   kb
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    // ---------------- receiver ----------------
    logic [2:0]      clk_s;     // [0],[1] synchronizer, [2] edge history
    logic [1:0]      dat_s;
    logic            fall;
    logic            ps2_d;
    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            parity_q;
    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic            frame_err_q;
    logic [WD_W-1:0] wd_q;

    assign fall  = clk_s[2] & ~clk_s[1];
    assign ps2_d = dat_s[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s       <= 3'b111;
            dat_s       <= 2'b11;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity_q    <= 1'b0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            frame_err_q <= 1'b0;
            wd_q        <= '0;
        end else begin
            clk_s       <= {clk_s[1:0], ps2_clk};
            dat_s       <= {dat_s[0], ps2_data};
            byte_valid  <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                wd_q <= '0;
                if (bit_cnt == 4'd0) begin
                    // a high "start" bit is treated as noise
                    if (!ps2_d) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {ps2_d, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    parity_q <= ps2_d;
                    bit_cnt  <= 4'd10;
                end else begin
                    bit_cnt <= '0;
                    if (ps2_d && (^{shreg, parity_q})) begin
                        rx_byte    <= shreg;
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (wd_q == WD_TC) begin
                    bit_cnt     <= '0;
                    wd_q        <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
            end else begin
                wd_q <= '0;
            end
        end
    end

    // ---------------- scan code to ASCII ----------------
    function automatic logic [7:0] to_ascii(input logic [7:0] code,
                                            input logic shift,
                                            input logic caps);
        logic [7:0] lc;
        logic [7:0] r;
        lc = 8'h00;
        r  = 8'h00;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
            8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
            8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
            8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
            8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
            8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
            8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            default: lc = 8'h00;
        endcase
        if (lc != 8'h00) begin
            r = (shift ^ caps) ? (lc - 8'h20) : lc;
        end else begin
            // digit row: caps lock has no effect, only shift
            case (code)
                8'h16: r = shift ? 8'h21 : 8'h31;
                8'h1E: r = shift ? 8'h40 : 8'h32;
                8'h26: r = shift ? 8'h23 : 8'h33;
                8'h25: r = shift ? 8'h24 : 8'h34;
                8'h2E: r = shift ? 8'h25 : 8'h35;
                8'h36: r = shift ? 8'h5E : 8'h36;
                8'h3D: r = shift ? 8'h26 : 8'h37;
                8'h3E: r = shift ? 8'h2A : 8'h38;
                8'h46: r = shift ? 8'h28 : 8'h39;
                8'h45: r = shift ? 8'h29 : 8'h30;
                8'h29: r = 8'h20;
                8'h5A: r = 8'h0D;
                8'h66: r = 8'h08;
                8'h0D: r = 8'h09;
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // ---------------- decoder ----------------
    state_t      state_q, state_d;
    logic        emit, ev_ext, ev_brk;
    logic        lshift_q, rshift_q, caps_q, caps_held_q;
    logic        lshift_d, rshift_d, caps_d, caps_held_d;
    logic        shift_d;
    logic [7:0]  ascii_d;
    logic [7:0]  seq_q;
    logic [31:0] wrdata_q;
    logic        we_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == 8'hE0)      state_d = S_EXT;
                    else if (rx_byte == 8'hF0) state_d = S_BRK;
                    else if (rx_byte == 8'hAA || rx_byte == 8'hFA ||
                             rx_byte == 8'hFE || rx_byte == 8'hEE)
                        state_d = S_IDLE;   // keyboard status bytes
                    else                       emit = 1'b1;
                end
                S_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    emit    = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    emit    = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Modifier state is updated first so the event word reflects the key
    // that was just pressed/released.
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (emit && !ev_ext) begin
            if (rx_byte == 8'h12) lshift_d = ~ev_brk;
            if (rx_byte == 8'h59) rshift_d = ~ev_brk;
            if (rx_byte == 8'h58) begin
                if (ev_brk) begin
                    caps_held_d = 1'b0;
                end else begin
                    // typematic repeat of caps lock must not re-toggle
                    if (!caps_held_q) caps_d = ~caps_q;
                    caps_held_d = 1'b1;
                end
            end
        end
        shift_d = lshift_d | rshift_d;
        ascii_d = (emit && !ev_ext && !ev_brk) ? to_ascii(rx_byte, shift_d, caps_d) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            seq_q       <= '0;
            wrdata_q    <= '0;
            we_q        <= 1'b0;
        end else begin
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            we_q        <= emit;
            if (emit) begin
                wrdata_q <= {seq_q, 4'b0000, ev_ext, ev_brk, caps_d, shift_d, rx_byte, ascii_d};
                seq_q    <= seq_q + 8'd1;
            end
        end
    end

    assign kb.kb_wraddr = KB_INFO_ADDR;
    assign kb.kb_wrdata = wrdata_q;
    assign kb.kb_we     = we_q;
    assign kb.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
module tb_ps2_kb_ctrl;
    localparam int TO = 300;   // shortened watchdog for simulation
    localparam int H  = 20;    // PS/2 half bit period in clk cycles

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_kb_ctrl_if kb_bus();

    ps2_kb_ctrl #(.TIMEOUT_CYCLES(TO), .KB_INFO_ADDR(32'h0050_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb       (kb_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int we_cnt  = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (kb_bus.kb_we)     we_cnt  <= we_cnt + 1;
        if (kb_bus.frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends one frame and checks the write/error timing relative to the
    // stop-bit falling edge: kb_we on the 4th clk after the pin drops
    // (2 sync + fall + byte_valid), frame_err on the 3rd.
    task automatic send_frame(input string tag, input logic [7:0] b,
                              input logic bad_par, input logic bad_stop,
                              input logic exp_we, input logic [31:0] exp_word,
                              input logic exp_err);
        logic [10:0] bits;
        int we_at, err_at, we_n;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        ps2_data = bits[10];
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        we_at = 0; err_at = 0; we_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (kb_bus.kb_we) begin we_n++; we_at = k; end
            if (kb_bus.frame_err) err_at = k;
            if (k == 4 && exp_we) chk({tag, " word"}, kb_bus.kb_wrdata, exp_word);
        end
        chk({tag, " we_cycle"}, we_at, exp_we ? 32'd4 : 32'd0);
        chk({tag, " we_count"}, we_n, exp_we ? 32'd1 : 32'd0);
        chk({tag, " err_cycle"}, err_at, exp_err ? 32'd3 : 32'd0);
        repeat (H) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic good(input string tag, input logic [7:0] b, input logic [31:0] w);
        send_frame(tag, b, 1'b0, 1'b0, 1'b1, w, 1'b0);
    endtask

    task automatic prefix(input string tag, input logic [7:0] b);
        send_frame(tag, b, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int e0, w0;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst wrdata", kb_bus.kb_wrdata, 32'h0);
        chk("rst we", {31'b0, kb_bus.kb_we}, 32'h0);
        chk("rst err", {31'b0, kb_bus.frame_err}, 32'h0);

        good("a", 8'h1C, 32'h00001C61);
        chk("wraddr", kb_bus.kb_wraddr, 32'h0050_0000);

        good("lshift make", 8'h12, 32'h01011200);
        good("A shifted", 8'h1C, 32'h02011C41);
        prefix("F0 a", 8'hF0);
        good("a break", 8'h1C, 32'h03051C00);
        prefix("F0 lshift", 8'hF0);
        good("lshift brk", 8'h12, 32'h04041200);

        prefix("E0 make", 8'hE0);
        good("ext make", 8'h75, 32'h05087500);
        prefix("E0 brk", 8'hE0);
        prefix("E0 F0", 8'hF0);
        good("ext break", 8'h75, 32'h060C7500);

        good("caps make", 8'h58, 32'h07025800);
        good("caps repeat", 8'h58, 32'h08025800);
        prefix("F0 caps", 8'hF0);
        good("caps break", 8'h58, 32'h09065800);
        good("Q caps", 8'h15, 32'h0A021551);

        good("rshift make", 8'h59, 32'h0B035900);
        good("bang", 8'h16, 32'h0C031621);
        good("a shift^caps", 8'h1C, 32'h0D031C61);
        prefix("F0 rshift", 8'hF0);
        good("rshift brk", 8'h59, 32'h0E065900);
        prefix("AA status", 8'hAA);

        send_frame("bad parity", 8'h1C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        send_frame("bad stop", 8'h1C, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        e0 = err_cnt; w0 = we_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 60) @(negedge clk);
        chk("timeout err", err_cnt - e0, 32'd1);
        chk("timeout we", we_cnt - w0, 32'd0);
        good("space", 8'h29, 32'h0F022920);

        w0 = we_cnt; e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst wrdata", kb_bus.kb_wrdata, 32'h0);
        chk("midrst we", {31'b0, kb_bus.kb_we}, 32'h0);
        chk("midrst err", {31'b0, kb_bus.frame_err}, 32'h0);
        rst = 1'b0;
        ps2_data = 1'b1;
        repeat (TO + 60) @(negedge clk);
        chk("midrst no write", we_cnt - w0, 32'd0);
        chk("midrst no err", err_cnt - e0, 32'd0);
        good("1 after rst", 8'h16, 32'h00001631);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
